// File: rtl/demux4_router.sv
// rtl/demux4_router.sv - 1-to-4 stream demultiplexer with per-channel FIFOs and a drop counter
module demux4_router #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [1:0]                 in_sel,
  output logic [3:0]                 out_valid,
  input  logic [3:0]                 out_ready,
  output logic [DATA_W-1:0]          out_a,
  output logic [DATA_W-1:0]          out_b,
  output logic [DATA_W-1:0]          out_c,
  output logic [DATA_W-1:0]          out_d,
  output logic [$clog2(DEPTH):0]     level_a,
  output logic [$clog2(DEPTH):0]     level_b,
  output logic [$clog2(DEPTH):0]     level_c,
  output logic [$clog2(DEPTH):0]     level_d,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wr_ptr [4];
  logic [PW-1:0]     rd_ptr [4];
  logic [PW-1:0]     level  [4];
  logic [AW-1:0]     nxt_rd [4];
  logic [DATA_W-1:0] mem    [4][DEPTH];
  logic [DATA_W-1:0] head   [4];
  logic [3:0]        full;
  logic [3:0]        push;
  logic [3:0]        pop;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      level[i]     = wr_ptr[i] - rd_ptr[i];
      full[i]      = (wr_ptr[i][PW-1] != rd_ptr[i][PW-1]) &&
                     (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      out_valid[i] = (level[i] != '0);
      nxt_rd[i]    = rd_ptr[i][AW-1:0] + 1'b1;
    end
  end

  // Readiness ignores pops in the same cycle, so a full channel never bypasses.
  assign in_ready = rst_n & ~full[in_sel];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      push[i] = in_valid & in_ready & (in_sel == 2'(i));
      pop[i]  = rst_n & out_valid[i] & out_ready[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        head[i]   <= '0;
      end
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i][AW-1:0]] <= in_data;
          wr_ptr[i]                 <= wr_ptr[i] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        // The head register tracks the oldest entry; it is loaded from in_data
        // only when the pushed word becomes the new head.
        if (pop[i]) begin
          if (level[i] > PW'(1)) begin
            head[i] <= mem[i][nxt_rd[i]];
          end else if (push[i]) begin
            head[i] <= in_data;
          end
        end else if (push[i] && (level[i] == '0)) begin
          head[i] <= in_data;
        end
      end
      if (in_valid && !in_ready && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign out_a   = head[0];
  assign out_b   = head[1];
  assign out_c   = head[2];
  assign out_d   = head[3];
  assign level_a = level[0];
  assign level_b = level[1];
  assign level_c = level[2];
  assign level_d = level[3];

endmodule

// File: tb/tb_demux4_router.sv
// tb/tb_demux4_router.sv - directed self-checking bench for demux4_router
module tb_demux4_router;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] out_a, out_b, out_c, out_d;
  logic [1:0] level_a, level_b, level_c, level_d;
  logic [7:0] drop_cnt;

  int tests = 0;
  int failed = 0;

  demux4_router #(.DATA_W(4), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .level_a(level_a), .level_b(level_b), .level_c(level_c), .level_d(level_d),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd0; in_data = 4'h0; out_ready = 4'h0;
    #1;
    check("rst_ready", in_ready, 0);
    tick(); tick();
    rst_n = 1'b1;
    drive(0, 0, 0);
    check("rst_valid", out_valid, 0);
    check("rst_levels", {level_a, level_b, level_c, level_d}, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_outs", {out_a, out_b, out_c, out_d}, 0);

    // routing
    out_ready = 4'hF;
    drive(1, 0, 4'h3); check("route_ready", in_ready, 1);
    tick(); check("route_va", out_valid, 4'b0001); check("route_a", out_a, 4'h3);
    drive(1, 1, 4'h5); tick(); check("route_vb", out_valid, 4'b0010); check("route_b", out_b, 4'h5);
    drive(1, 2, 4'hA); tick(); check("route_vc", out_valid, 4'b0100); check("route_c", out_c, 4'hA);
    drive(1, 3, 4'hF); tick(); check("route_vd", out_valid, 4'b1000); check("route_d", out_d, 4'hF);
    drive(0, 0, 0); tick();
    check("route_idle", out_valid, 0); check("route_hold_d", out_d, 4'hF); check("route_drop", drop_cnt, 0);

    // backpressure on b
    out_ready = 4'b1101;
    drive(1, 1, 4'h1); tick();
    drive(1, 1, 4'h2); tick();
    check("bp_level_b", level_b, 2); check("bp_out_b", out_b, 4'h1);
    drive(1, 1, 4'h9); check("bp_ready", in_ready, 0);
    tick(); check("bp_drop1", drop_cnt, 1);
    tick(); check("bp_drop2", drop_cnt, 2); check("bp_level_b2", level_b, 2);

    // independence
    drive(1, 2, 4'h7); check("ind_ready", in_ready, 1);
    tick(); check("ind_out_c", out_c, 4'h7); check("ind_level_c", level_c, 1);
    check("ind_valid", out_valid, 4'b0110); check("ind_drop", drop_cnt, 2);
    drive(0, 0, 0); tick(); check("ind_valid2", out_valid, 4'b0010);

    // no bypass on a full channel that pops
    out_ready = 4'hF;
    drive(1, 1, 4'h9); check("nobypass_ready", in_ready, 0);
    tick(); check("nobypass_drop", drop_cnt, 3); check("nobypass_lvl", level_b, 1); check("nobypass_out", out_b, 4'h2);
    drive(0, 0, 0); tick(); check("drain_b", level_b, 0); check("drain_valid", out_valid, 0);

    // ordering with concurrent push/pop
    out_ready = 4'h0;
    drive(1, 0, 4'h1); tick();
    drive(1, 0, 4'h2); tick();
    check("ord_lvl2", level_a, 2); check("ord_head1", out_a, 4'h1);
    out_ready = 4'h1;
    drive(1, 0, 4'h3); check("ord_full_ready", in_ready, 0);
    tick(); check("ord_head2", out_a, 4'h2); check("ord_lvl1", level_a, 1); check("ord_drop", drop_cnt, 4);
    check("ord_ready", in_ready, 1);
    tick(); check("ord_head3", out_a, 4'h3); check("ord_pushpop_lvl", level_a, 1);
    drive(0, 0, 0); tick(); check("ord_empty", level_a, 0); check("ord_hold", out_a, 4'h3);

    // drop counter saturation
    out_ready = 4'h0;
    drive(1, 1, 4'h4); tick();
    drive(1, 1, 4'h5); tick();
    for (int i = 0; i < 300; i++) tick();
    check("sat_drop", drop_cnt, 255);
    tick(); check("sat_hold", drop_cnt, 255);
    check("sat_out_b", out_b, 4'h4); check("sat_level_b", level_b, 2);

    // reset mid-stream
    drive(1, 0, 4'h6); tick();
    drive(1, 0, 4'h8); tick();
    drive(1, 2, 4'hB); tick();
    drive(0, 3, 0);
    check("pre_rst_levels", {level_a, level_b, level_c, level_d}, {2'd2, 2'd2, 2'd1, 2'd0});
    rst_n = 1'b0; #1;
    check("mid_rst_ready", in_ready, 0);
    tick();
    rst_n = 1'b1; #1;
    check("post_rst_levels", {level_a, level_b, level_c, level_d}, 0);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_drop", drop_cnt, 0);
    check("post_rst_outs", {out_a, out_b, out_c, out_d}, 0);
    drive(1, 3, 4'hC); check("post_rst_ready", in_ready, 1);
    tick(); check("post_rst_d", out_d, 4'hC); check("post_rst_vd", out_valid, 4'b1000); check("post_rst_lvl_d", level_d, 1);
    out_ready = 4'b1000;
    drive(0, 0, 0); tick(); check("post_rst_pop", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
